wb_result_unit: RTL and testbench

// - Registered writeback-result stage; successor to the single LUI/load 2:1 select.
// - Picks ALU result, aligned/extended load data, shifted immediate (LUI) or link address, then issues one register-file write.
// - Sits between EX/MEM and the register file.
// - Waits on a variable-latency data memory, with timeout and error flagging.

---
 rtl/mips_wb_pkg.sv | 35 +++
 rtl/load_align_ext.sv | 28 ++
 rtl/wb_result_unit.sv | 182 ++++++++++++++++++
 tb/tb_wb_result_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared encodings for the writeback-result stage: source select, load size and FSM states.
package mips_wb_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_LUI  = 2'd2,
        SEL_LINK = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } ld_size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    // Reserved size is treated as misaligned so the request is dropped with an error.
    function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (ld_size_e'(size))
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'd0);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load-data alignment: selects the addressed byte/half of the raw
// memory word and sign- or zero-extends it to the full datapath width.
module load_align_ext
    import mips_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        case (ld_size_e'(size))
            SZ_BYTE: data = {{(DATA_W-8){byte_v[7] & ~uns}}, byte_v};
            SZ_HALF: data = {{(DATA_W-16){half_v[15] & ~uns}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_result_unit.sv
// Registered writeback-result stage: selects ALU/load/LUI/link result and issues a
// single register-file write, waiting on variable-latency memory for loads.
module wb_result_unit
    import mips_wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_uns,
    input  logic [1:0]         in_byte_off,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [DATA_W-1:0]  in_link,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               wb_valid,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               err_align,
    output logic               err_timeout,
    output logic               err_spur
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    wb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ld_size_q, ld_size_d;
    logic               ld_uns_q, ld_uns_d;
    logic [1:0]         ld_off_q, ld_off_d;
    logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;

    logic               wb_valid_q, wb_valid_d;
    logic [RADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               err_align_q, err_align_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_spur_q, err_spur_d;

    logic               accept;
    logic               is_load;
    logic               misaligned;
    logic               cnt_last;
    logic [DATA_W-1:0]  imm_res;
    logic [DATA_W-1:0]  ld_word;

    load_align_ext #(
        .DATA_W(DATA_W)
    ) u_align (
        .rdata(mem_rdata),
        .size (ld_size_q),
        .uns  (ld_uns_q),
        .off  (ld_off_q),
        .data (ld_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ld_size_q     <= '0;
            ld_uns_q      <= 1'b0;
            ld_off_q      <= '0;
            ld_rd_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_spur_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ld_size_q     <= ld_size_d;
            ld_uns_q      <= ld_uns_d;
            ld_off_q      <= ld_off_d;
            ld_rd_q       <= ld_rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
            err_spur_q    <= err_spur_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        accept     = in_valid & in_ready;
        is_load    = (wb_sel_e'(in_sel) == SEL_LOAD);
        misaligned = ld_misaligned(in_ld_size, in_byte_off);
        cnt_last   = (cnt_q == CNT_W'(TIMEOUT - 1));
        case (wb_sel_e'(in_sel))
            SEL_LUI:  imm_res = DATA_W'(in_imm) << (DATA_W - IMM_W);
            SEL_LINK: imm_res = in_link;
            default:  imm_res = in_alu;
        endcase
    end

    // Next-state: FSM, wait counter and latched load descriptor.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        ld_off_d  = ld_off_q;
        ld_rd_d   = ld_rd_q;
        case (state_q)
            IDLE: begin
                if (accept && is_load && !misaligned) begin
                    state_d   = WAIT_MEM;
                    cnt_d     = '0;
                    ld_size_d = in_ld_size;
                    ld_uns_d  = in_ld_uns;
                    ld_off_d  = in_byte_off;
                    ld_rd_d   = in_rd;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid || cnt_last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: write strobe is suppressed for r0 but data/address still update.
    always_comb begin
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        err_align_d   = err_align_q;
        err_timeout_d = err_timeout_q;
        err_spur_d    = err_spur_q;
        case (state_q)
            IDLE: begin
                if (mem_rvalid) begin
                    err_spur_d = 1'b1;
                end
                if (accept) begin
                    if (!is_load) begin
                        wb_valid_d = (in_rd != '0);
                        wb_rd_d    = in_rd;
                        wb_data_d  = imm_res;
                    end else if (misaligned) begin
                        err_align_d = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    wb_valid_d = (ld_rd_q != '0);
                    wb_rd_d    = ld_rd_q;
                    wb_data_d  = ld_word;
                end else if (cnt_last) begin
                    err_timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign err_align   = err_align_q;
    assign err_timeout = err_timeout_q;
    assign err_spur    = err_spur_q;

endmodule

// File: tb/tb_wb_result_unit.sv
// Testbench for wb_result_unit: directed vector table, hand sequences for timeout
// and reset corner cases, then random traffic against a behavioural model.
module tb_wb_result_unit;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [1:0]  in_ld_size;
    logic        in_ld_uns;
    logic [1:0]  in_byte_off;
    logic [31:0] in_alu;
    logic [15:0] in_imm;
    logic [31:0] in_link;
    logic [4:0]  in_rd;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_align;
    logic        err_timeout;
    logic        err_spur;

    int checks = 0;
    int errors = 0;

    wb_result_unit #(
        .DATA_W (32),
        .IMM_W  (16),
        .RADDR_W(5),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_ld_size (in_ld_size),
        .in_ld_uns  (in_ld_uns),
        .in_byte_off(in_byte_off),
        .in_alu     (in_alu),
        .in_imm     (in_imm),
        .in_link    (in_link),
        .in_rd      (in_rd),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err_align  (err_align),
        .err_timeout(err_timeout),
        .err_spur   (err_spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference model
    bit          m_pend;
    int          m_wait;
    int          p_size;
    bit          p_uns;
    int          p_off;
    logic [4:0]  p_rd;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_align, m_timeout, m_spur;

    function automatic bit is_mis(input int size, input int off);
        return (size == 3) || (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input int size,
                                            input bit uns, input int off);
        int unsigned v;
        if (size == 0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pend = 0; m_wait = 0;
            m_valid = 0; m_rd = 0; m_data = 0;
            m_align = 0; m_timeout = 0; m_spur = 0;
        end else begin
            m_valid = 0;
            if (!m_pend) begin
                if (mem_rvalid) m_spur = 1;
                if (in_valid) begin
                    if (in_sel != 2'd1) begin
                        m_rd = in_rd;
                        if (in_sel == 2'd0)      m_data = in_alu;
                        else if (in_sel == 2'd2) m_data = {in_imm, 16'h0000};
                        else                     m_data = in_link;
                        m_valid = (in_rd != 0);
                    end else if (is_mis(int'(in_ld_size), int'(in_byte_off))) begin
                        m_align = 1;
                    end else begin
                        m_pend = 1; m_wait = 0;
                        p_size = int'(in_ld_size); p_uns = in_ld_uns;
                        p_off = int'(in_byte_off); p_rd = in_rd;
                    end
                end
            end else if (mem_rvalid) begin
                m_data = extract(mem_rdata, p_size, p_uns, p_off);
                m_rd = p_rd;
                m_valid = (p_rd != 0);
                m_pend = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_timeout = 1;
                    m_pend = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m_wb_valid", 32'(wb_valid), 32'(m_valid));
        chk("m_wb_rd", 32'(wb_rd), 32'(m_rd));
        chk("m_wb_data", wb_data, m_data);
        chk("m_err_align", 32'(err_align), 32'(m_align));
        chk("m_err_timeout", 32'(err_timeout), 32'(m_timeout));
        chk("m_err_spur", 32'(err_spur), 32'(m_spur));
        chk("m_in_ready", 32'(in_ready), 32'(!m_pend));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [15:0] imm;
        logic [31:0] link;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          waits;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_align;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        // sel size uns off alu imm link rd rdata waits valid chkdata data align
        vecs[0]  = '{2'd2, 2'd0, 1'b0, 2'd0, 32'h0, 16'h1234, 32'h0, 5'd8, 32'h0, 0, 1'b1, 1'b1, 32'h1234_0000, 1'b0};
        vecs[1]  = '{2'd1, 2'd0, 1'b0, 2'd3, 32'h0, 16'h0, 32'h0, 5'd3, 32'h80FF_FF7F, 2, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{2'd1, 2'd0, 1'b1, 2'd3, 32'h0, 16'h0, 32'h0, 5'd3, 32'h80FF_FF7F, 2, 1'b1, 1'b1, 32'h0000_0080, 1'b0};
        vecs[3]  = '{2'd0, 2'd0, 1'b0, 2'd0, 32'hDEAD_BEEF, 16'h0, 32'h0, 5'd0, 32'h0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{2'd3, 2'd0, 1'b0, 2'd0, 32'h0, 16'h0, 32'h0040_0108, 5'd31, 32'h0, 0, 1'b1, 1'b1, 32'h0040_0108, 1'b0};
        vecs[5]  = '{2'd1, 2'd1, 1'b0, 2'd2, 32'h0, 16'h0, 32'h0, 5'd4, 32'h8001_1234, 1, 1'b1, 1'b1, 32'hFFFF_8001, 1'b0};
        vecs[6]  = '{2'd1, 2'd1, 1'b1, 2'd0, 32'h0, 16'h0, 32'h0, 5'd9, 32'h5555_F00D, 3, 1'b1, 1'b1, 32'h0000_F00D, 1'b0};
        vecs[7]  = '{2'd1, 2'd2, 1'b0, 2'd0, 32'h0, 16'h0, 32'h0, 5'd10, 32'hCAFE_BABE, 0, 1'b1, 1'b1, 32'hCAFE_BABE, 1'b0};
        vecs[8]  = '{2'd1, 2'd0, 1'b0, 2'd1, 32'h0, 16'h0, 32'h0, 5'd11, 32'h0000_7F00, 4, 1'b1, 1'b1, 32'h0000_007F, 1'b0};
        vecs[9]  = '{2'd1, 2'd1, 1'b0, 2'd1, 32'h0, 16'h0, 32'h0, 5'd12, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[10] = '{2'd1, 2'd3, 1'b0, 2'd0, 32'h0, 16'h0, 32'h0, 5'd13, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_ld_size = '0; in_ld_uns = 1'b0;
        in_byte_off = '0; in_alu = '0; in_imm = '0; in_link = '0; in_rd = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_errs", {29'd0, err_align, err_timeout, err_spur}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            in_sel = vecs[i].sel; in_ld_size = vecs[i].size; in_ld_uns = vecs[i].uns;
            in_byte_off = vecs[i].off; in_alu = vecs[i].alu; in_imm = vecs[i].imm;
            in_link = vecs[i].link; in_rd = vecs[i].rd;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (vecs[i].sel == 2'd1 && !vecs[i].exp_align) begin
                for (int w = 0; w < vecs[i].waits; w++) begin
                    chk("vec_wait_valid", 32'(wb_valid), 32'd0);
                    mem_rdata = $urandom;
                    step();
                end
                mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
                step();
                mem_rvalid = 1'b0;
            end
            chk($sformatf("vec%0d_valid", i), 32'(wb_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_align", i), 32'(err_align), 32'(vecs[i].exp_align));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("vec%0d_pulse", i), 32'(wb_valid), 32'd0);
        end

        // Timeout: a word load with no response for TIMEOUT cycles is abandoned
        in_sel = 2'd1; in_ld_size = 2'd2; in_byte_off = 2'd0; in_rd = 5'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < TIMEOUT - 1; c++) step();
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        chk("to_busy", 32'(in_ready), 32'd0);
        step();
        chk("to_flag", 32'(err_timeout), 32'd1);
        chk("to_idle", 32'(in_ready), 32'd1);
        chk("to_no_write", 32'(wb_valid), 32'd0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("late_spur", 32'(err_spur), 32'd1);
        chk("late_no_write", 32'(wb_valid), 32'd0);

        // Reset while a load is pending discards it
        in_sel = 2'd1; in_ld_size = 2'd2; in_rd = 5'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        step();
        reset = 1'b0; mem_rvalid = 1'b0;
        chk("mrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mrst_wb_rd", 32'(wb_rd), 32'd0);
        chk("mrst_wb_data", wb_data, 32'd0);
        chk("mrst_errs", {29'd0, err_align, err_timeout, err_spur}, 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mrst_no_write", 32'(wb_valid), 32'd0);
        end
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("mrst_spur", 32'(err_spur), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            in_valid    = ($urandom_range(0, 9) < 6);
            in_sel      = 2'($urandom_range(0, 3));
            in_ld_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            in_ld_uns   = 1'($urandom);
            in_byte_off = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            in_alu      = $urandom;
            in_imm      = 16'($urandom);
            in_link     = $urandom;
            in_rd       = 5'($urandom);
            mem_rdata   = $urandom;
            if (m_pend) mem_rvalid = ($urandom_range(0, 99) < 20);
            else        mem_rvalid = ($urandom_range(0, 99) < 5);
            step();
        end
        reset = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
